bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/bus_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus arbiter constants, ID field width and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_parameters;

    localparam int         BITS      = 16;
    localparam int         DRVRS     = 4;
    localparam logic [7:0] BROADCAST = 8'hFF;
    localparam int         ID_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DELIVER = 2'd2
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit searching upward from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] grant,
    output logic          vld
);

    logic [GW-1:0] idx;

    // Walk the ring starting just after the previous winner; first hit wins.
    always_comb begin
        grant = '0;
        vld   = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = GW'((int'(last_grant) + off) % N);
            if (!vld && req[idx]) begin
                grant = idx;
                vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin shared-bus arbiter: pops one source FIFO head and routes it to its destination(s); drop counter under BUS_DROP_CNT_EN.
// Latency: pop one cycle after pndng is sampled, push the cycle after that; one packet per 3 cycles at most.
// Backpressure: sources wait on pndng until granted; receivers cannot stall, unroutable packets are dropped.
module bus_rr_arbiter #(
    parameter int         BITS      = bus_parameters::BITS,
    parameter int         DRVRS     = bus_parameters::DRVRS,
    parameter logic [7:0] BROADCAST = bus_parameters::BROADCAST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DRVRS-1:0]            pndng,
    input  logic [DRVRS-1:0][BITS-1:0]  D_pop,
    output logic [DRVRS-1:0]            pop,
    output logic [DRVRS-1:0]            push,
    output logic [BITS-1:0]             D_push
`ifdef BUS_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    import bus_parameters::*;

    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic [DRVRS-1:0] pop_q, pop_d;
    logic [DRVRS-1:0] push_q, push_d;
    logic [BITS-1:0]  data_q, data_d;

    logic [GW-1:0]    pick_idx;
    logic             pick_vld;

    // Unroutable: not broadcast and either out of range or looping back to the source.
    function automatic logic is_drop(input logic [ID_W-1:0] dest, input logic [GW-1:0] src);
        return (dest != BROADCAST) &&
               ((int'(dest) >= DRVRS) || (int'(dest) == int'(src)));
    endfunction

    function automatic logic [DRVRS-1:0] route(input logic [ID_W-1:0] dest, input logic [GW-1:0] src);
        logic [DRVRS-1:0] v;
        v = '0;
        if (dest == BROADCAST) begin
            v      = '1;
            v[src] = 1'b0;
        end else if (!is_drop(dest, src)) begin
            v[dest[GW-1:0]] = 1'b1;
        end
        return v;
    endfunction

    rr_priority_picker #(
        .N  (DRVRS),
        .GW (GW)
    ) u_picker (
        .req        (pndng),
        .last_grant (last_q),
        .grant      (pick_idx),
        .vld        (pick_vld)
    );

    // Next-state and registered-strobe decode; grant and data are only taken
    // in IDLE/CAPTURE so later pndng activity cannot disturb a packet in flight.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pop_d   = '0;
        push_d  = '0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d         = pick_idx;
                    pop_d[pick_idx] = 1'b1;
                    state_d         = CAPTURE;
                end
            end
            CAPTURE: begin
                data_d  = D_pop[grant_q];
                push_d  = route(D_pop[grant_q][BITS-1 -: ID_W], grant_q);
                state_d = DELIVER;
            end
            DELIVER: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant pointer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(DRVRS - 1);
            pop_q   <= '0;
            push_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            data_q  <= data_d;
        end
    end

    assign pop    = pop_q;
    assign push   = push_q;
    assign D_push = data_q;

`ifdef BUS_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count each dropped packet once, in its DELIVER cycle, saturating at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == DELIVER) && is_drop(data_q[BITS-1 -: ID_W], grant_q) &&
            (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (4 agents, 16-bit packets); drop counter checked under BUS_DROP_CNT_EN.
// Latency: inputs change and outputs are sampled on the falling edge.
// Backpressure: n/a.
module tb_bus_rr_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       pndng;
    logic [3:0][15:0] d_pop;
    logic [3:0]       pop;
    logic [3:0]       push;
    logic [15:0]      d_push;
`ifdef BUS_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected push vector per source agent for the round-robin traffic.
    logic [3:0] rr_push_exp [4];

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .BITS      (16),
        .DRVRS     (4),
        .BROADCAST (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push)
`ifdef BUS_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rr_push_exp[0] = 4'b0010;
        rr_push_exp[1] = 4'b0100;
        rr_push_exp[2] = 4'b1000;
        rr_push_exp[3] = 4'b0001;

        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        repeat (2) @(negedge clk);
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_dpush", 32'(d_push), 32'h0);
`ifdef BUS_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 32'h0);
`endif

        // First packet after reset: agent 0 to agent 2.
        d_pop[0] = 16'h0255;
        pndng    = 4'b0001;
        reset    = 1'b0;
        @(negedge clk);
        check("first_pop", 32'(pop), 32'h1);
        check("first_push_early", 32'(push), 32'h0);
        pndng = '0;
        @(negedge clk);
        check("first_push", 32'(push), 32'h4);
        check("first_dpush", 32'(d_push), 32'h0255);
        check("first_pop_once", 32'(pop), 32'h0);
        @(negedge clk);
        check("first_push_once", 32'(push), 32'h0);
        check("dpush_hold", 32'(d_push), 32'h0255);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_pop", 32'(pop), 32'h0);
            check("idle_push", 32'(push), 32'h0);
        end

        // All four agents pending: grants rotate from agent 0, one pop every 3 cycles.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        d_pop[0] = 16'h01A0;
        d_pop[1] = 16'h02A1;
        d_pop[2] = 16'h03A2;
        d_pop[3] = 16'h00A3;
        pndng    = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_pop", 32'(pop), 32'(1) << (k % 4));
            @(negedge clk);
            check("rr_push", 32'(push), 32'(rr_push_exp[k % 4]));
            check("rr_dpush", 32'(d_push), 32'(d_pop[k % 4]));
            check("rr_gap1", 32'(pop), 32'h0);
            if (k == 7) pndng = '0;
            @(negedge clk);
            check("rr_gap2", 32'(pop), 32'h0);
            check("rr_push_off", 32'(push), 32'h0);
        end

        // Broadcast from agent 2 reaches everyone else.
        d_pop[2] = 16'hFFAA;
        pndng    = 4'b0100;
        @(negedge clk);
        check("bc_pop", 32'(pop), 32'h4);
        pndng = '0;
        @(negedge clk);
        check("bc_push", 32'(push), 32'hB);
        check("bc_dpush", 32'(d_push), 32'hFFAA);
        @(negedge clk);
        check("bc_push_off", 32'(push), 32'h0);

        // Out-of-range destination, then self-addressed: both dropped.
        d_pop[1] = 16'h0712;
        pndng    = 4'b0010;
        @(negedge clk);
        check("drop_hi_pop", 32'(pop), 32'h2);
        pndng = '0;
        @(negedge clk);
        check("drop_hi_push", 32'(push), 32'h0);
        check("drop_hi_dpush", 32'(d_push), 32'h0712);
        @(negedge clk);
`ifdef BUS_DROP_CNT_EN
        check("drop_cnt1", 32'(drop_cnt), 32'h1);
`endif
        d_pop[1] = 16'h0155;
        pndng    = 4'b0010;
        @(negedge clk);
        check("drop_self_pop", 32'(pop), 32'h2);
        pndng = '0;
        @(negedge clk);
        check("drop_self_push", 32'(push), 32'h0);
        check("drop_self_dpush", 32'(d_push), 32'h0155);
        @(negedge clk);
`ifdef BUS_DROP_CNT_EN
        check("drop_cnt2", 32'(drop_cnt), 32'h2);
`endif

        // Reset in the middle of CAPTURE aborts agent 3's packet.
        d_pop[3] = 16'h0033;
        pndng    = 4'b1000;
        @(negedge clk);
        check("abort_pop", 32'(pop), 32'h8);
        #1 reset = 1'b1;
        #1;
        check("abort_pop_clr", 32'(pop), 32'h0);
        check("abort_push_clr", 32'(push), 32'h0);
        check("abort_dpush_clr", 32'(d_push), 32'h0);
`ifdef BUS_DROP_CNT_EN
        check("abort_drop_clr", 32'(drop_cnt), 32'h0);
`endif
        pndng    = 4'b1010;
        d_pop[1] = 16'h0211;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(pop), 32'h2);
        check("post_rst_no_push", 32'(push), 32'h0);
        pndng    = 4'b1000;
        d_pop[3] = 16'h0133;
        @(negedge clk);
        check("post_rst_push", 32'(push), 32'h4);
        check("post_rst_dpush", 32'(d_push), 32'h0211);
        @(negedge clk);
        check("post_rst_push_off", 32'(push), 32'h0);

        // Agent 3 withdraws pndng during DELIVER; the packet still completes.
        @(negedge clk);
        check("late_pop", 32'(pop), 32'h8);
        @(posedge clk);
        #2 pndng = '0;
        @(negedge clk);
        check("late_push", 32'(push), 32'h2);
        check("late_dpush", 32'(d_push), 32'h0133);
        @(negedge clk);
        check("late_push_off", 32'(push), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_idle_pop", 32'(pop), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
